// File: rtl/axi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_ram_arbiter
// Purpose  : Shares one AXI4 RAM slave port between the instruction-fetch (IF)
//            and data-memory (MEM) requesters of a five-stage core. One
//            request is in flight at a time. Arbitration is round-robin when
//            both requesters are valid in the same cycle.
// Ports    : clock/reset        - clock, asynchronous active-low reset
//            if_req_* / if_resp_*   - fetch read request / response pulse
//            mem_req_* / mem_resp_* - data read/write request / response pulse
//            ram_aw*/ram_w*/ram_b*  - RAM write address, data, response
//            ram_ar*/ram_rdata      - RAM read address and read data
// Revision : 1.0 - initial release
// ============================================================================
module axi_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  // fetch requester
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_rdata,
  // data requester
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_wen,
  input  logic [DATA_W-1:0] mem_req_wdata,
  input  logic [STRB_W-1:0] mem_req_wstrb,
  output logic              mem_resp_valid,
  output logic [DATA_W-1:0] mem_resp_rdata,
  // RAM write channels
  output logic [ADDR_W-1:0] ram_awaddr,
  output logic              ram_awvalid,
  input  logic              ram_awready,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [STRB_W-1:0] ram_wstrb,
  output logic              ram_wvalid,
  input  logic              ram_wready,
  input  logic              ram_bvalid,
  // RAM read channels
  output logic [ADDR_W-1:0] ram_araddr,
  output logic              ram_arvalid,
  input  logic              ram_arready,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t state;
  logic   last_grant_if;  // 1: most recent grant went to IF, 0: to MEM
  logic   owner_if;       // owner of the transaction in flight
  logic   aw_done;
  logic   w_done;

  logic   in_idle;
  logic   grant_if;
  logic   grant_mem;

  // Contention goes to the requester that did not win last time; a lone
  // requester always wins. Reset leaves last_grant on MEM so IF wins first.
  assign in_idle   = (state == IDLE);
  assign grant_if  = in_idle && if_req_valid  && (!mem_req_valid || !last_grant_if);
  assign grant_mem = in_idle && mem_req_valid && (!if_req_valid  ||  last_grant_if);

  assign if_req_ready  = grant_if;
  assign mem_req_ready = grant_mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant_if  <= 1'b0;
      owner_if       <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      if_resp_valid  <= 1'b0;
      if_resp_rdata  <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
      ram_awaddr     <= '0;
      ram_awvalid    <= 1'b0;
      ram_wdata      <= '0;
      ram_wstrb      <= '0;
      ram_wvalid     <= 1'b0;
      ram_araddr     <= '0;
      ram_arvalid    <= 1'b0;
    end else begin
      // Response strobes are single-cycle pulses.
      if_resp_valid  <= 1'b0;
      mem_resp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_if) begin
            owner_if      <= 1'b1;
            last_grant_if <= 1'b1;
            ram_araddr    <= if_req_addr;
            ram_arvalid   <= 1'b1;
            state         <= RD_ADDR;
          end else if (grant_mem) begin
            owner_if      <= 1'b0;
            last_grant_if <= 1'b0;
            if (mem_req_wen) begin
              ram_awaddr  <= mem_req_addr;
              ram_wdata   <= mem_req_wdata;
              ram_wstrb   <= mem_req_wstrb;
              ram_awvalid <= 1'b1;
              ram_wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR_REQ;
            end else begin
              ram_araddr  <= mem_req_addr;
              ram_arvalid <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (ram_arready) begin
            ram_arvalid <= 1'b0;
            state       <= RD_DATA;
          end
        end

        // Read data is valid the cycle after the AR handshake; it is loaded
        // straight into the owner's response register so the pulse in RESP
        // carries it.
        RD_DATA: begin
          if (owner_if) begin
            if_resp_rdata <= ram_rdata;
            if_resp_valid <= 1'b1;
          end else begin
            mem_resp_rdata <= ram_rdata;
            mem_resp_valid <= 1'b1;
          end
          state <= RESP;
        end

        // AW and W complete independently; leave once both have completed,
        // counting a ready that arrives in this very cycle.
        WR_REQ: begin
          if (ram_awvalid && ram_awready) begin
            ram_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (ram_wvalid && ram_wready) begin
            ram_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || ram_awready) && (w_done || ram_wready)) begin
            state <= WR_RESP;
          end
        end

        // Only MEM issues writes, so the completion always goes to MEM.
        WR_RESP: begin
          if (ram_bvalid) begin
            mem_resp_rdata <= '0;
            mem_resp_valid <= 1'b1;
            state          <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ram_arbiter
// Purpose  : Directed self-checking bench for axi_ram_arbiter. The bench acts
//            as both requesters and as the RAM, driving inputs one cycle at a
//            time and comparing outputs with hand-computed values.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic              clock;
  logic              reset;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic [ADDR_W-1:0] ram_awaddr;
  logic              ram_awvalid;
  logic              ram_awready;
  logic [DATA_W-1:0] ram_wdata;
  logic [STRB_W-1:0] ram_wstrb;
  logic              ram_wvalid;
  logic              ram_wready;
  logic              ram_bvalid;
  logic [ADDR_W-1:0] ram_araddr;
  logic              ram_arvalid;
  logic              ram_arready;
  logic [DATA_W-1:0] ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  axi_ram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STRB_W(STRB_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_rdata  (if_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .ram_awaddr     (ram_awaddr),
    .ram_awvalid    (ram_awvalid),
    .ram_awready    (ram_awready),
    .ram_wdata      (ram_wdata),
    .ram_wstrb      (ram_wstrb),
    .ram_wvalid     (ram_wvalid),
    .ram_wready     (ram_wready),
    .ram_bvalid     (ram_bvalid),
    .ram_araddr     (ram_araddr),
    .ram_arvalid    (ram_arvalid),
    .ram_arready    (ram_arready),
    .ram_rdata      (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to the start of the next cycle (inputs driven here).
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Move to the middle of the current cycle (outputs sampled here).
  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    logic        is_if;

    reset         = 1'b0;
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    ram_awready   = 1'b0;
    ram_wready    = 1'b0;
    ram_bvalid    = 1'b0;
    ram_arready   = 1'b0;
    ram_rdata     = '0;

    // ---------------- reset state ----------------
    cyc();
    cyc();
    mid();
    check_eq("rst_arvalid", ram_arvalid, 0);
    check_eq("rst_awvalid", ram_awvalid, 0);
    check_eq("rst_wvalid", ram_wvalid, 0);
    check_eq("rst_resp_valid", {if_resp_valid, mem_resp_valid}, 0);
    check_eq("rst_rdata", if_resp_rdata | mem_resp_rdata, 0);
    check_eq("rst_addr", {ram_awaddr, ram_araddr}, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // ---------------- round-robin, both requesters reading ----------------
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0000_1000;
    mem_req_valid = 1'b1;
    mem_req_addr  = 32'h0000_2000;
    mem_req_wen   = 1'b0;
    for (int g = 0; g < 4; g++) begin
      is_if = (g % 2 == 0);
      d     = 64'hA5A5_0000_0000_0000 + 64'(g);
      mid();
      check_eq($sformatf("arb%0d_if_ready", g), if_req_ready, is_if);
      check_eq($sformatf("arb%0d_mem_ready", g), mem_req_ready, !is_if);
      check_eq($sformatf("arb%0d_no_resp_idle", g), {if_resp_valid, mem_resp_valid}, 0);
      cyc();
      ram_arready = 1'b1;
      mid();
      check_eq($sformatf("arb%0d_arvalid", g), ram_arvalid, 1);
      check_eq($sformatf("arb%0d_araddr", g), ram_araddr, is_if ? 32'h0000_1000 : 32'h0000_2000);
      check_eq($sformatf("arb%0d_ready_busy", g), {if_req_ready, mem_req_ready}, 0);
      cyc();
      ram_arready = 1'b0;
      ram_rdata   = d;
      mid();
      cyc();
      ram_rdata = '0;
      mid();
      check_eq($sformatf("arb%0d_if_resp", g), if_resp_valid, is_if);
      check_eq($sformatf("arb%0d_mem_resp", g), mem_resp_valid, !is_if);
      check_eq($sformatf("arb%0d_rdata", g), is_if ? if_resp_rdata : mem_resp_rdata, d);
      cyc();
    end
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    mid();
    check_eq("arb_resp_single", {if_resp_valid, mem_resp_valid}, 0);
    cyc();

    // ---------------- MEM write, W delayed ----------------
    mem_req_valid = 1'b1;
    mem_req_wen   = 1'b1;
    mem_req_addr  = 32'h8000_1000;
    mem_req_wdata = 64'hDEAD_BEEF_CAFE_BABE;
    mem_req_wstrb = 8'h0F;
    mid();
    check_eq("wr_mem_ready", mem_req_ready, 1);
    check_eq("wr_if_ready", if_req_ready, 0);
    cyc();                                   // T+1
    mem_req_valid = 1'b0;
    mem_req_wen   = 1'b0;
    ram_awready   = 1'b1;
    mid();
    check_eq("wr_awvalid_t1", ram_awvalid, 1);
    check_eq("wr_wvalid_t1", ram_wvalid, 1);
    check_eq("wr_awaddr", ram_awaddr, 32'h8000_1000);
    check_eq("wr_wdata", ram_wdata, 64'hDEAD_BEEF_CAFE_BABE);
    check_eq("wr_wstrb", ram_wstrb, 8'h0F);
    cyc();                                   // T+2
    ram_awready = 1'b0;
    mid();
    check_eq("wr_awvalid_t2", ram_awvalid, 0);
    check_eq("wr_wvalid_t2", ram_wvalid, 1);
    cyc();                                   // T+3
    ram_wready = 1'b1;
    mid();
    check_eq("wr_wvalid_t3", ram_wvalid, 1);
    cyc();                                   // T+4
    ram_wready = 1'b0;
    ram_bvalid = 1'b1;
    mid();
    check_eq("wr_wvalid_t4", ram_wvalid, 0);
    check_eq("wr_resp_t4", mem_resp_valid, 0);
    cyc();                                   // T+5
    ram_bvalid = 1'b0;
    mid();
    check_eq("wr_resp_t5", mem_resp_valid, 1);
    check_eq("wr_rdata_zero", mem_resp_rdata, 0);
    check_eq("wr_if_resp_t5", if_resp_valid, 0);
    cyc();
    mid();
    check_eq("wr_resp_t6", mem_resp_valid, 0);
    cyc();

    // ---------------- IF-only read ----------------
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0000;
    mid();
    check_eq("rd_if_ready", if_req_ready, 1);
    cyc();                                   // T+1
    if_req_valid = 1'b0;
    ram_arready  = 1'b1;
    mid();
    check_eq("rd_arvalid", ram_arvalid, 1);
    check_eq("rd_araddr", ram_araddr, 32'h8000_0000);
    cyc();                                   // T+2
    ram_arready = 1'b0;
    ram_rdata   = 64'h0000_0013_0000_0093;
    mid();
    check_eq("rd_arvalid_drop", ram_arvalid, 0);
    check_eq("rd_resp_early", if_resp_valid, 0);
    cyc();                                   // T+3
    ram_rdata = '0;
    mid();
    check_eq("rd_resp_t3", if_resp_valid, 1);
    check_eq("rd_rdata", if_resp_rdata, 64'h0000_0013_0000_0093);
    check_eq("rd_mem_resp", mem_resp_valid, 0);
    cyc();
    mid();
    check_eq("rd_resp_t4", if_resp_valid, 0);
    check_eq("rd_rdata_hold", if_resp_rdata, 64'h0000_0013_0000_0093);
    cyc();

    // ---------------- AR stall ----------------
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0040;
    mid();
    cyc();
    if_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check_eq($sformatf("stall%0d_arvalid", i), ram_arvalid, 1);
      check_eq($sformatf("stall%0d_araddr", i), ram_araddr, 32'h8000_0040);
      cyc();
    end
    ram_arready = 1'b1;
    mid();
    cyc();
    ram_arready = 1'b0;
    ram_rdata   = 64'h1122_3344_5566_7788;
    mid();
    check_eq("stall_resp_early", if_resp_valid, 0);
    cyc();
    ram_rdata = '0;
    mid();
    check_eq("stall_resp", if_resp_valid, 1);
    check_eq("stall_rdata", if_resp_rdata, 64'h1122_3344_5566_7788);
    cyc();

    // ---------------- reset during WR_RESP ----------------
    mem_req_valid = 1'b1;
    mem_req_wen   = 1'b1;
    mem_req_addr  = 32'h8000_2000;
    mem_req_wdata = 64'h0123_4567_89AB_CDEF;
    mem_req_wstrb = 8'hFF;
    mid();
    cyc();
    mem_req_valid = 1'b0;
    mem_req_wen   = 1'b0;
    ram_awready   = 1'b1;
    ram_wready    = 1'b1;
    mid();
    check_eq("rw_awvalid", ram_awvalid, 1);
    cyc();                                   // now in WR_RESP
    ram_awready = 1'b0;
    ram_wready  = 1'b0;
    mid();
    check_eq("rw_wr_idle_valid", {ram_awvalid, ram_wvalid}, 0);
    check_eq("rw_no_resp_yet", mem_resp_valid, 0);
    reset      = 1'b0;
    ram_bvalid = 1'b1;
    #1;
    check_eq("rw_awaddr_clr", ram_awaddr, 0);
    check_eq("rw_wdata_clr", ram_wdata, 0);
    check_eq("rw_wstrb_clr", ram_wstrb, 0);
    check_eq("rw_araddr_clr", ram_araddr, 0);
    check_eq("rw_if_rdata_clr", if_resp_rdata, 0);
    check_eq("rw_valids_clr", {ram_arvalid, ram_awvalid, ram_wvalid, if_resp_valid, mem_resp_valid}, 0);
    cyc();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ram_bvalid = 1'b0;
      mid();
      check_eq($sformatf("rw_no_resp%0d", i), mem_resp_valid, 0);
      cyc();
    end
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0000_3000;
    mem_req_valid = 1'b1;
    mem_req_addr  = 32'h0000_4000;
    mid();
    check_eq("rw_if_first", if_req_ready, 1);
    check_eq("rw_mem_wait", mem_req_ready, 0);
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_ram_arbiter.md
Name: axi_ram_arbiter

Overview:
- Shares the single AXI4_Ram slave port between the five-stage core's instruction-fetch (IF) and data-memory (MEM) requesters.
- Accepts one simple valid/ready request at a time and arbitrates round-robin.
- Drives the RAM's AW/W/AR channels and returns a one-cycle response pulse with read data to the owning requester.
- Sits between the pipeline's fetch/LSU stages and the RAM.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 64, data width on all ports.
- STRB_W, DATA_W/8, write-strobe width.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch read request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDR_W  fetch address.
- if_resp_valid  out  1  one-cycle fetch response pulse.
- if_resp_rdata  out  DATA_W  fetch read data, valid with if_resp_valid.
- mem_req_valid  in  1  data request.
- mem_req_ready  out  1  data request accepted.
- mem_req_addr  in  ADDR_W  data address.
- mem_req_wen  in  1  1 = write, 0 = read.
- mem_req_wdata  in  DATA_W  write data.
- mem_req_wstrb  in  STRB_W  byte enables.
- mem_resp_valid  out  1  one-cycle data response pulse (read or write completion).
- mem_resp_rdata  out  DATA_W  read data; 0 for writes.
- ram_awaddr / ram_awvalid  out  ADDR_W / 1  AW channel.
- ram_awready  in  1  AW ready.
- ram_wdata / ram_wstrb / ram_wvalid  out  DATA_W / STRB_W / 1  W channel.
- ram_wready  in  1  W ready.
- ram_bvalid  in  1  write complete.
- ram_araddr / ram_arvalid  out  ADDR_W / 1  AR channel.
- ram_arready  in  1  AR ready.
- ram_rdata  in  DATA_W  read data, valid the cycle after the AR handshake.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- Reset (reset low, async):
  - State becomes IDLE; last_grant becomes MEM, so IF wins the first contention.
  - All valid/ready outputs are 0; all address, data and strobe output registers are 0.
  - Any in-flight transaction is abandoned; no response is emitted for it.
- IDLE arbitration:
  - if_req_ready and mem_req_ready are driven combinationally; at most one is high.
  - Only one requester valid: grant it.
  - Both valid: grant the requester opposite last_grant.
  - On handshake, register addr, wen (IF forced to 0), wdata, wstrb and owner; update last_grant.
  - Next state: RD_ADDR if wen=0, WR_REQ if wen=1.
  - Requester inputs are ignored outside IDLE.
- RD_ADDR:
  - ram_arvalid=1 and ram_araddr=captured addr, held stable until ram_arready.
  - On the handshake go to RD_DATA.
- RD_DATA:
  - Register ram_rdata into the response data register; go to RESP.
- WR_REQ:
  - ram_awvalid and ram_wvalid are both raised on entry.
  - Each is dropped independently after its own ready is seen; aw_done and w_done flags track this.
  - Same-cycle awready and wready is legal.
  - When both are done (including the cycle the last one completes), go to WR_RESP.
- WR_RESP:
  - Wait for ram_bvalid; then clear the response data register to 0 and go to RESP.
  - A bvalid seen in any other state is ignored.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle, with resp_rdata = registered data.
  - Go to IDLE; no request is accepted in RESP.
- Latency with zero-wait RAM, read: handshake at cycle T, arvalid at T+1, data captured at T+2, resp_valid at T+3.
- Latency with zero-wait RAM, write: handshake at T, AW/W at T+1, bvalid observed at T+2 at the earliest, resp_valid one cycle after bvalid.
- Non-owner resp_valid is always 0. Response data outputs hold their last value between pulses.
- Addresses are passed unmodified; there is no alignment checking.

Test Plan:
- IF-only read, addr 0x80000000, RAM returns 0x00000013_00000093 the cycle after arready → if_resp_valid single pulse at T+3 with that data; mem_resp_valid stays 0.
- MEM write, addr 0x80001000, wdata 0xDEADBEEF_CAFEBABE, wstrb 0x0F; awready at T+1, wready delayed to T+3, bvalid at T+4 → awvalid drops after T+1, wvalid drops after T+3; mem_resp_valid at T+5 with rdata 0.
- Both valid every cycle, reads only → grants alternate IF, MEM, IF, MEM (IF first after reset); each receives exactly one response per grant.
- arready held low 5 cycles → ram_arvalid and ram_araddr stable all 5 cycles; response follows 2 cycles after the eventual handshake.
- reset low during WR_RESP → all outputs 0 immediately; no resp_valid is ever emitted for that write; after release, an IF request is granted first.
